// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared definitions for the instruction fetch stage: FSM state
//               encodings, instruction-word field positions, default halt
//               opcode, opcode width shared with exe_engine, word splitter.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // FSM state encodings (STEP is only reachable in single-step builds)
    localparam int unsigned              c_STATE_W  = 3;
    localparam logic [c_STATE_W-1:0]     c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0]     c_ST_FETCH = 3'd1;
    localparam logic [c_STATE_W-1:0]     c_ST_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0]     c_ST_ISSUE = 3'd3;
    localparam logic [c_STATE_W-1:0]     c_ST_HALT  = 3'd4;
    localparam logic [c_STATE_W-1:0]     c_ST_STEP  = 3'd5;

    // Opcode width shared with exe_engine and the default halt opcode
    localparam int unsigned              c_OPCODE_W = 4;
    localparam logic [c_OPCODE_W-1:0]    c_HALT_OP  = 4'hF;

    // Instruction-word field positions (each field is 8 bits wide)
    localparam int unsigned              c_FIELD_W   = 8;
    localparam int unsigned              c_OP_LSB    = 24;
    localparam int unsigned              c_DST_LSB   = 16;
    localparam int unsigned              c_SRC1_LSB  = 8;
    localparam int unsigned              c_SRC2_LSB  = 0;

    typedef struct packed {
        logic [c_FIELD_W-1:0] op;
        logic [c_FIELD_W-1:0] dst;
        logic [c_FIELD_W-1:0] src1;
        logic [c_FIELD_W-1:0] src2;
    } imem_word_t;

    // Split a raw memory word into its raw 8-bit fields
    function automatic imem_word_t split_word(input logic [31:0] word);
        imem_word_t f;
        f.op   = word[c_OP_LSB   +: c_FIELD_W];
        f.dst  = word[c_DST_LSB  +: c_FIELD_W];
        f.src1 = word[c_SRC1_LSB +: c_FIELD_W];
        f.src2 = word[c_SRC2_LSB +: c_FIELD_W];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Program counter register with synchronous clear, increment
//               and silent modulo-2^WIDTH wrap; asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over increment; increment wraps naturally
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch/issue stage feeding exe_engine. Fetches
//               32-bit words from a synchronous instruction memory, splits
//               them into opcode/operand fields and issues them with a
//               valid/ready handshake. The halt opcode stops fetching until
//               the next start pulse.
//               Optional macro FETCH_SINGLE_STEP_EN adds a 'step' input and a
//               STEP state entered after every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         OPCODE_W = c_OPCODE_W,
    parameter logic [OPCODE_W-1:0] HALT_OP  = OPCODE_W'(c_HALT_OP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                imem_rd_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [OPCODE_W-1:0] instr,
    output logic [ADDR_W-1:0]   dst,
    output logic [ADDR_W-1:0]   src1,
    output logic [ADDR_W-1:0]   src2,
    output logic                instr_valid,
    input  logic                exe_ready,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted
);

    logic [c_STATE_W-1:0] state_q;
    logic [c_STATE_W-1:0] state_d;

    logic [OPCODE_W-1:0]  instr_q;
    logic [ADDR_W-1:0]    dst_q;
    logic [ADDR_W-1:0]    src1_q;
    logic [ADDR_W-1:0]    src2_q;

    imem_word_t           w_word;
    logic [OPCODE_W-1:0]  w_opcode;
    logic                 w_is_halt;
    logic                 w_start_ok;
    logic                 w_handshake;
    logic                 w_unused_word;

    assign w_word        = split_word(imem_rdata);
    assign w_opcode      = w_word.op[OPCODE_W-1:0];
    assign w_is_halt     = (w_opcode == HALT_OP);
    // Opcode bits above OPCODE_W (and address bits beyond ADDR_W) are ignored
    assign w_unused_word = ^w_word;

    // start only counts when the stage is parked
    assign w_start_ok  = start && ((state_q == c_ST_IDLE) || (state_q == c_ST_HALT));
    assign w_handshake = (state_q == c_ST_ISSUE) && exe_ready;

    // Program counter: cleared by an accepted start, bumped by each handshake
    pc_counter #(
        .WIDTH   (ADDR_W)
    ) u_pc_counter (
        .clk     (clk),
        .rst_n_i (reset),
        .clr_i   (w_start_ok),
        .inc_i   (w_handshake),
        .count_o (pc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE,
            c_ST_HALT:  if (start) state_d = c_ST_FETCH;
            c_ST_FETCH: state_d = c_ST_WAIT;
            c_ST_WAIT:  state_d = w_is_halt ? c_ST_HALT : c_ST_ISSUE;
`ifdef FETCH_SINGLE_STEP_EN
            c_ST_ISSUE: if (exe_ready) state_d = c_ST_STEP;
            c_ST_STEP:  if (step) state_d = c_ST_FETCH;
`else
            c_ST_ISSUE: if (exe_ready) state_d = c_ST_FETCH;
`endif
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and pc only
    always_comb begin
        imem_rd_en  = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state_q)
            c_ST_FETCH: begin
                imem_rd_en = 1'b1;
                imem_addr  = pc;
                busy       = 1'b1;
            end
            c_ST_WAIT:  busy = 1'b1;
            c_ST_ISSUE: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
            end
            c_ST_STEP:  busy = 1'b1;
            c_ST_HALT:  halted = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // Field-split registers: loaded in WAIT, held through ISSUE stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            dst_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
        end else if (state_q == c_ST_WAIT) begin
            instr_q <= w_opcode;
            dst_q   <= ADDR_W'(w_word.dst);
            src1_q  <= ADDR_W'(w_word.src1);
            src2_q  <= ADDR_W'(w_word.src2);
        end
    end

    assign instr = instr_q;
    assign dst   = dst_q;
    assign src1  = src1_q;
    assign src2  = src2_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: cycle-vector table for
//               the basic program/halt/stall/restart sequence, randomized
//               program with a transaction-level scoreboard (including pc
//               wrap), asynchronous reset mid-ISSUE, and single-step mode
//               when FETCH_SINGLE_STEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

`ifdef FETCH_SINGLE_STEP_EN
    localparam int c_GAP = 4;
`else
    localparam int c_GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        exe_ready;
`ifdef FETCH_SINGLE_STEP_EN
    logic        step;
`endif
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [3:0]  instr;
    logic [7:0]  dst, src1, src2, pc;
    logic        instr_valid, busy, halted;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_count = 0;
    int sb_idx   = 0;
    int last_hs  = 0;
    bit sb_en    = 1'b0;
    logic prev_valid = 1'b0;

    typedef struct {
        bit         start, rdy, chk_f, rd_en;
        logic [7:0] addr;
        bit         valid;
        logic [3:0] instr;
        logic [7:0] dst, src1, src2, pc;
        bit         busy, halted;
    } vec_t;

    instr_fetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef FETCH_SINGLE_STEP_EN
        .step        (step),
`endif
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .dst         (dst),
        .src1        (src1),
        .src2        (src2),
        .instr_valid (instr_valid),
        .exe_ready   (exe_ready),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit s, bit r, bit f, bit rd, int a, bit v, int ins,
                                int d, int s1, int s2, int p, bit b, bit h);
        vec_t x;
        x.start = s;  x.rdy = r;  x.chk_f = f;  x.rd_en = rd;
        x.addr  = 8'(a);  x.valid = v;  x.instr = 4'(ins);
        x.dst   = 8'(d);  x.src1 = 8'(s1);  x.src2 = 8'(s2);
        x.pc    = 8'(p);  x.busy = b;  x.halted = h;
        return x;
    endfunction

    // Handshake counter
    always @(negedge clk) begin
        if (reset && instr_valid && exe_ready) hs_count <= hs_count + 1;
    end

    // Transaction scoreboard: the k-th issued instruction is the word at
    // address k mod 256, pc equals that address, fetches go to that address,
    // and a new instruction appears c_GAP cycles after the previous handshake.
    always @(negedge clk) begin
        logic [31:0] w;
        if (sb_en) begin
            w = mem[sb_idx % 256];
            if (imem_rd_en)
                chk("sb.fetch_addr", 32'(imem_addr), 32'(sb_idx % 256));
            if (instr_valid) begin
                chk("sb.instr", 32'(instr), 32'(w[27:24]));
                chk("sb.dst",   32'(dst),   32'(w[23:16]));
                chk("sb.src1",  32'(src1),  32'(w[15:8]));
                chk("sb.src2",  32'(src2),  32'(w[7:0]));
                chk("sb.pc",    32'(pc),    32'(sb_idx % 256));
                if (!prev_valid && sb_idx > 0)
                    chk("sb.issue_gap", 32'(cyc - last_hs), 32'(c_GAP));
                if (exe_ready) begin
                    sb_idx  = sb_idx + 1;
                    last_hs = cyc;
                end
            end
        end
        prev_valid <= instr_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   budget;
        int   w;
        int   hs_before;
        bit   seen;
        logic [31:0] rw;

        reset = 1'b0; start = 1'b0; exe_ready = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h01020304;
        mem[1] = 32'h02050607;
        mem[2] = 32'h0F000000;

        tick(); tick();
        chk("rst.pc",     32'(pc), 0);
        chk("rst.valid",  32'(instr_valid), 0);
        chk("rst.rd_en",  32'(imem_rd_en), 0);
        chk("rst.busy",   32'(busy), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.instr",  32'({instr, dst, src1, src2}), 0);
        reset = 1'b1;
        tick();
        chk("idle.busy", 32'(busy), 0);

`ifndef FETCH_SINGLE_STEP_EN
        //            st rdy chk rd adr v  ins d  s1 s2 pc b  h
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // FETCH @0
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // WAIT
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 2, 3, 4, 0, 1, 0)); // ISSUE instr 1
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 2, 3, 4, 1, 1, 0)); // FETCH @1
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 2, 3, 4, 1, 1, 0)); // WAIT
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 5, 6, 7, 1, 1, 0)); // ISSUE instr 2
        tbl.push_back(mk(0, 1, 1, 1, 2, 0, 2, 5, 6, 7, 2, 1, 0)); // FETCH @2
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2, 5, 6, 7, 2, 1, 0)); // WAIT (halt word)
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1)); // HALT
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1)); // stays HALT
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // restart -> FETCH @0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // start in WAIT ignored
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 2, 3, 4, 0, 1, 0)); // ISSUE
        for (int k = 0; k < 5; k++)                               // 5 stall cycles
            tbl.push_back(mk(k == 1, 0, 1, 0, 0, 1, 1, 2, 3, 4, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 2, 3, 4, 1, 1, 0)); // handshake -> FETCH @1

        foreach (tbl[i]) begin
            start     = tbl[i].start;
            exe_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d.rd_en", i),  32'(imem_rd_en),  32'(tbl[i].rd_en));
            chk($sformatf("v%0d.addr", i),   32'(imem_addr),   32'(tbl[i].addr));
            chk($sformatf("v%0d.valid", i),  32'(instr_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d.pc", i),     32'(pc),          32'(tbl[i].pc));
            chk($sformatf("v%0d.busy", i),   32'(busy),        32'(tbl[i].busy));
            chk($sformatf("v%0d.halted", i), 32'(halted),      32'(tbl[i].halted));
            if (tbl[i].chk_f)
                chk($sformatf("v%0d.fields", i), {instr, 4'h0, dst, src1, src2},
                    {tbl[i].instr, 4'h0, tbl[i].dst, tbl[i].src1, tbl[i].src2});
            if (i == 9) chk("prog.two_handshakes", 32'(hs_count), 2);
        end
        start = 1'b0;
`endif

        // Randomized program covering pc wrap past 8'hFF
        reset = 1'b0;
        tick(); tick();
        for (int i = 0; i < 256; i++) begin
            rw = $urandom();
            if (rw[27:24] == 4'hF) rw[27:24] = 4'h3;
            mem[i] = rw;
        end
        reset = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1;
`endif
        tick();
        sb_idx = 0;
        sb_en  = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        budget = 0;
        while (sb_idx < 260 && budget < 3000) begin
            exe_ready = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
        end
        chk("rand.done", 32'(sb_idx >= 260), 1);
        sb_en = 1'b0;

        // Asynchronous reset in the middle of an ISSUE cycle
        exe_ready = 1'b0;
        w = 0;
        while (!instr_valid && w < 10) begin
            tick();
            w++;
        end
        chk("arst.reached_issue", 32'(instr_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.valid",  32'(instr_valid), 0);
        chk("arst.pc",     32'(pc), 0);
        chk("arst.fields", {instr, 4'h0, dst, src1, src2}, 0);
        chk("arst.ctrl",   32'({imem_rd_en, imem_addr, busy, halted}), 0);
        tick(); tick();
        reset     = 1'b1;
        exe_ready = 1'b1;
        hs_before = hs_count;
        seen      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (instr_valid || busy || imem_rd_en) seen = 1'b1;
        end
        chk("arst.no_issue_wo_start", 32'(seen), 0);
        chk("arst.no_handshake", 32'(hs_count - hs_before), 0);

`ifdef FETCH_SINGLE_STEP_EN
        // Single-step: park in STEP after the handshake until step pulses
        step  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!instr_valid && w < 10) begin
            tick();
            w++;
        end
        chk("step.first_issue", 32'(instr_valid), 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("step.parked_valid", 32'(instr_valid), 0);
            chk("step.parked_busy",  32'(busy), 1);
            chk("step.parked_pc",    32'(pc), 1);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        exe_ready = 1'b0;
        chk("step.fetch_rd",   32'(imem_rd_en), 1);
        chk("step.fetch_addr", 32'(imem_addr), 1);
        chk("step.c1_valid",   32'(instr_valid), 0);
        tick();
        chk("step.c2_valid",   32'(instr_valid), 0);
        tick();
        chk("step.c3_valid",   32'(instr_valid), 1);
        rw = mem[1];
        chk("step.c3_instr",   32'(instr), 32'(rw[27:24]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
